// File: rtl/vmx_mm_scheduler.sv
// Job queue, launch FSM, address remapper and watchdog in front of the
// vmx_mm_wrapper matrix engine.
module vmx_mm_scheduler #(
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned START_TO = 16,
  parameter int unsigned RUN_TO   = 1024,
  parameter int unsigned DST_OFS  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_src,
  input  logic [7:0]  cmd_dst,
  output logic [31:0] eng_ctrl,
  input  logic [31:0] eng_flag,
  input  logic [7:0]  eng_addr,
  input  logic        eng_wr_en,
  output logic [7:0]  mem_addr,
  output logic        mem_wr_en,
  output logic        busy,
  output logic [4:0]  q_level,
  output logic [15:0] done_cnt,
  output logic        irq,
  input  logic        irq_clr,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned WW = $clog2((RUN_TO > START_TO) ? RUN_TO : START_TO) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_RUN, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    fifo_q [QDEPTH];
  logic [15:0]    fifo_d [QDEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [7:0]     job_src_q, job_src_d, job_dst_q, job_dst_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic           start_q, start_d, abort_q, abort_d;
  logic [15:0]    done_cnt_q, done_cnt_d;
  logic           irq_q, irq_d, err_q, err_d;
  logic           push, pop, to_err, eng_active;

  assign eng_active = |eng_flag;
  assign cmd_ready  = (cnt_q != 5'(QDEPTH)) && (state_q != S_ERR);
  assign push       = cmd_valid && cmd_ready;

  always_comb begin
    state_d    = state_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    job_src_d  = job_src_q;
    job_dst_d  = job_dst_q;
    wd_d       = wd_q;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    done_cnt_d = done_cnt_q;
    err_d      = err_q;
    pop        = 1'b0;
    to_err     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          job_src_d = fifo_q[rd_ptr_q][15:8];
          job_dst_d = fifo_q[rd_ptr_q][7:0];
          start_d   = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_active) begin
          wd_d    = '0;
          state_d = S_RUN;
        end else if (wd_q == WW'(START_TO - 1)) begin
          to_err = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!eng_active) begin
          state_d = S_DONE;
        end else if (wd_q == WW'(RUN_TO - 1)) begin
          to_err = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE: begin
        pop        = 1'b1;
        done_cnt_d = done_cnt_q + 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = {cmd_src, cmd_dst};
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + 5'(push) - 5'(pop);

    // A watchdog trip flushes the queue, overriding any push in the same cycle.
    if (to_err) begin
      state_d  = S_ERR;
      abort_d  = 1'b1;
      err_d    = 1'b1;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    irq_d = irq_q;
    if (irq_clr) irq_d = 1'b0;
    if (state_q == S_DONE) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int unsigned i = 0; i < QDEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      job_src_q  <= '0;
      job_dst_q  <= '0;
      wd_q       <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      done_cnt_q <= '0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      job_src_q  <= job_src_d;
      job_dst_q  <= job_dst_d;
      wd_q       <= wd_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      done_cnt_q <= done_cnt_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
    end
  end

  // Engine-local addresses below DST_OFS hit the operand region, the rest the result region.
  always_comb begin
    if (eng_addr < 8'(DST_OFS)) mem_addr = job_src_q + eng_addr;
    else                        mem_addr = job_dst_q + (eng_addr - 8'(DST_OFS));
  end

  assign mem_wr_en = eng_wr_en && (state_q == S_RUN);
  assign eng_ctrl  = {30'd0, start_q, abort_q};
  assign busy      = (state_q != S_IDLE);
  assign q_level   = cnt_q;
  assign done_cnt  = done_cnt_q;
  assign irq       = irq_q;
  assign err       = err_q;

endmodule
